// File: rtl/d_buf_pkg.sv
// Shared widths, bank geometry and read FSM encoding for the ping-pong byte/word buffers.
// Pure declarations: no logic, no latency, no flow control.
package d_buf_pkg;
   localparam int DW_OUT = 8;
   localparam int DW_IN  = 2 * DW_OUT;
   localparam int DEPTH  = 256;
   localparam int AW     = $clog2(DEPTH);

   typedef logic bank_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_FETCH,
      RD_HI,
      RD_LO
   } rd_state_t;
endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with 1-cycle latency.
// Read data holds its last value while rd_en is low; no flow control of its own.
module dp_ram #(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/d_unbuf.sv
// Ping-pong word-to-byte unpacker: fills one bank of 16-bit words while the other streams out MSB-first.
// First byte 3 cycles after a bank's last write; output holds under out_rdy low, data_rdy drops while both banks are full.
module d_unbuf #(
   parameter int DEPTH  = d_buf_pkg::DEPTH,
   parameter int DW_IN  = d_buf_pkg::DW_IN,
   parameter int DW_OUT = d_buf_pkg::DW_OUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW_IN-1:0]  data_in,
   input  logic              data_v,
   output logic              data_rdy,
   output logic              data_ov,
   output logic [DW_OUT-1:0] data_out,
   input  logic              out_rdy,
   output logic              frame_start,
   output logic              frame_end,
   output logic              ovf
);
   import d_buf_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [1:0]       full_q, full_d;
   bank_t            wr_bank_q, wr_bank_d;
   bank_t            rd_bank_q, rd_bank_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   rd_state_t        state_q, state_d;
   logic [DW_IN-1:0] word_q, word_d;
   logic             data_ov_q, data_ov_d;
   logic [DW_OUT-1:0] data_out_q, data_out_d;
   logic             fs_q, fs_d;
   logic             fe_q, fe_d;
   logic             ovf_q, ovf_d;

   logic             wr_en;
   logic             rd_en;
   logic [PTR_W:0]   rd_addr;
   logic [DW_IN-1:0] ram_rdata;

   assign data_rdy = !full_q[wr_bank_q];
   assign wr_en    = data_v && data_rdy;

   dp_ram #(
      .DW(DW_IN),
      .AW(PTR_W + 1)
   ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en),
      .wr_addr({wr_bank_q, wr_ptr_q}),
      .wr_data(data_in),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(ram_rdata)
   );

   always_comb begin
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      wr_ptr_d   = wr_ptr_q;
      rd_bank_d  = rd_bank_q;
      rd_ptr_d   = rd_ptr_q;
      state_d    = state_q;
      word_d     = word_q;
      data_ov_d  = data_ov_q;
      data_out_d = data_out_q;
      fs_d       = fs_q;
      fe_d       = fe_q;
      ovf_d      = ovf_q | (data_v & ~data_rdy);
      rd_en      = 1'b0;
      rd_addr    = {rd_bank_q, rd_ptr_q};

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (wr_ptr_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end

      // The writer only ever fills a free bank and the reader only releases a full one,
      // so the set above and the clear below never target the same bank.
      case (state_q)
         RD_IDLE: begin
            if (full_q[rd_bank_q]) begin
               rd_en   = 1'b1;
               rd_addr = {rd_bank_q, {PTR_W{1'b0}}};
               state_d = RD_FETCH;
            end
         end
         RD_FETCH: begin
            word_d     = ram_rdata;
            data_out_d = ram_rdata[DW_IN-1:DW_OUT];
            data_ov_d  = 1'b1;
            fs_d       = (rd_ptr_q == '0);
            fe_d       = 1'b0;
            state_d    = RD_HI;
         end
         RD_HI: begin
            if (out_rdy) begin
               data_out_d = word_q[DW_OUT-1:0];
               fs_d       = 1'b0;
               fe_d       = (rd_ptr_q == LAST);
               rd_en      = 1'b1;
               rd_addr    = {rd_bank_q, rd_ptr_q + 1'b1};
               state_d    = RD_LO;
            end
         end
         RD_LO: begin
            if (out_rdy) begin
               fe_d = 1'b0;
               if (rd_ptr_q != LAST) begin
                  word_d     = ram_rdata;
                  data_out_d = ram_rdata[DW_IN-1:DW_OUT];
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  fs_d       = 1'b0;
                  state_d    = RD_HI;
               end else begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = ~rd_bank_q;
                  rd_ptr_d          = '0;
                  data_ov_d         = 1'b0;
                  state_d           = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= 2'b00;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= RD_IDLE;
         word_q     <= '0;
         data_ov_q  <= 1'b0;
         data_out_q <= '0;
         fs_q       <= 1'b0;
         fe_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         word_q     <= word_d;
         data_ov_q  <= data_ov_d;
         data_out_q <= data_out_d;
         fs_q       <= fs_d;
         fe_q       <= fe_d;
         ovf_q      <= ovf_d;
      end
   end

   assign data_ov     = data_ov_q;
   assign data_out    = data_out_q;
   assign frame_start = fs_q;
   assign frame_end   = fe_q;
   assign ovf         = ovf_q;
endmodule

// File: tb/tb_d_unbuf.sv
// Directed bench for d_unbuf: word writer, byte collector and expected-byte scoreboard.
// Received entries are {frame_start, frame_end, byte}, stamped with the cycle they transferred.
module tb_d_unbuf;
   localparam int WPB = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        data_v;
   logic        data_rdy;
   logic        data_ov;
   logic [7:0]  data_out;
   logic        out_rdy;
   logic        frame_start;
   logic        frame_end;
   logic        ovf;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int stall_err = 0;
   int wcnt = 0;
   int sidx = 0;
   logic [9:0] rx_q[$];
   logic [9:0] exp_q[$];
   int         rx_t[$];
   logic       prev_stall = 1'b0;
   logic [9:0] prev_out = '0;

   d_unbuf dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_v     (data_v),
      .data_rdy   (data_rdy),
      .data_ov    (data_ov),
      .data_out   (data_out),
      .out_rdy    (out_rdy),
      .frame_start(frame_start),
      .frame_end  (frame_end),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte collector plus hold-while-stalled watch.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !(data_ov && ({frame_start, frame_end, data_out} == prev_out)))
            stall_err++;
         if (data_ov && out_rdy) begin
            rx_q.push_back({frame_start, frame_end, data_out});
            rx_t.push_back(cyc);
         end
         prev_stall = data_ov && !out_rdy;
         prev_out   = {frame_start, frame_end, data_out};
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back({(wcnt % WPB == 0), 1'b0, w[15:8]});
      exp_q.push_back({1'b0, (wcnt % WPB == WPB - 1), w[7:0]});
      wcnt++;
   endtask

   // Offers words only while data_rdy is high, so nothing is ever dropped here.
   task automatic write_words(input int n, input logic [15:0] base, input logic [15:0] step);
      int i = 0;
      int g = 0;
      logic [15:0] w;
      while (i < n && g < 4 * n + 4000) begin
         @(posedge clk); #1;
         g++;
         if (data_rdy) begin
            w       = base + 16'(i) * step;
            data_v  = 1'b1;
            data_in = w;
            push_word(w);
            i++;
         end else begin
            data_v = 1'b0;
         end
      end
      @(posedge clk); #1;
      data_v = 1'b0;
      chk("words accepted", i, n);
   endtask

   task automatic drain(input int budget);
      int g = 0;
      while (rx_q.size() < exp_q.size() && g < budget) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string tag);
      chk({tag, " byte count"}, rx_q.size(), exp_q.size());
      for (int i = sidx; i < rx_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s byte %0d", tag, i), {22'd0, rx_q[i]}, {22'd0, exp_q[i]});
         if (rx_q[i] !== exp_q[i]) break;
      end
      sidx = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
   endtask

   // Within a bank bytes are back-to-back; after frame_end the next frame starts 3 cycles later.
   task automatic check_gaps(input int from, input string tag);
      int bad = 0;
      for (int j = from; j + 1 < rx_t.size(); j++)
         if (rx_t[j+1] - rx_t[j] != (rx_q[j][8] ? 3 : 1)) bad++;
      chk({tag, " gap errors"}, bad, 0);
   endtask

   task automatic rand_rdy(input int target);
      int g = 0;
      while (rx_q.size() < target && g < 20000) begin
         @(posedge clk); #1;
         out_rdy = 1'($urandom_range(0, 1));
         g++;
      end
      out_rdy = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " data_ov"}, data_ov, 0);
      chk({tag, " data_out"}, data_out, 0);
      chk({tag, " frame_start"}, frame_start, 0);
      chk({tag, " frame_end"}, frame_end, 0);
      chk({tag, " ovf"}, ovf, 0);
      chk({tag, " data_rdy"}, data_rdy, 1);
   endtask

   initial begin
      int p;
      int g;
      int target;

      rst = 1'b1; data_v = 1'b0; data_in = '0; out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      chk("post-reset data_ov", data_ov, 0);

      // Single bank 0x0100+i: first byte exactly 3 cycles after the last write.
      p = rx_q.size();
      write_words(WPB, 16'h0100, 16'h0001);
      @(negedge clk); chk("latency N+1 data_ov", data_ov, 0);
      @(negedge clk); chk("latency N+2 data_ov", data_ov, 0);
      @(negedge clk); chk("latency N+3 data_ov", data_ov, 1);
      chk("latency N+3 first byte", {22'd0, frame_start, frame_end, data_out}, 32'h201);
      drain(2000);
      check_stream("single");
      check_gaps(p, "single");

      // 32 banks back-to-back.
      p = rx_q.size();
      write_words(32 * WPB, 16'hA5C3, 16'h0137);
      drain(3000);
      check_stream("continuous");
      check_gaps(p, "continuous");
      chk("continuous ovf", ovf, 0);

      // Random backpressure across 4 banks.
      target = exp_q.size() + 8 * WPB;
      fork
         write_words(4 * WPB, 16'h3C00, 16'h0B0D);
         rand_rdy(target);
      join
      drain(2000);
      check_stream("backpressure");
      chk("stall hold errors", stall_err, 0);

      // Both banks full, then one word that must be dropped.
      out_rdy = 1'b0;
      write_words(2 * WPB, 16'h7E01, 16'h0301);
      @(negedge clk);
      chk("both full data_rdy", data_rdy, 0);
      chk("both full data_ov held", data_ov, 1);
      @(posedge clk); #1;
      data_v = 1'b1; data_in = 16'hDEAD;
      @(posedge clk); #1;
      data_v = 1'b0;
      @(negedge clk);
      chk("overflow ovf", ovf, 1);
      chk("overflow data_rdy", data_rdy, 0);
      chk("overflow held byte", {22'd0, frame_start, frame_end, data_out}, {22'd0, exp_q[sidx]});
      out_rdy = 1'b1;
      drain(3000);
      check_stream("both full");

      // Last word of the write bank lands on the edge that releases the read bank.
      write_words(WPB, 16'h1111, 16'h0202);
      write_words(WPB - 1, 16'h4000, 16'h0011);
      g = 0;
      while (!(data_ov && frame_end) && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      chk("simultaneous frame_end reached", data_ov && frame_end, 1);
      chk("simultaneous data_rdy before", data_rdy, 1);
      data_v = 1'b1;
      data_in = 16'h4000 + 16'(WPB - 1) * 16'h0011;
      push_word(data_in);
      @(posedge clk); #1;
      data_v = 1'b0;
      @(negedge clk);
      chk("simultaneous data_rdy after", data_rdy, 1);
      chk("simultaneous IDLE data_ov", data_ov, 0);
      @(negedge clk);
      chk("simultaneous FETCH data_ov", data_ov, 0);
      @(negedge clk);
      chk("simultaneous restart data_ov", data_ov, 1);
      chk("simultaneous restart frame_start", frame_start, 1);
      drain(2000);
      check_stream("simultaneous");

      // Reset after 100 bytes of a bank; the rest of that bank is discarded.
      p = rx_q.size();
      write_words(WPB, 16'h9000, 16'h0105);
      g = 0;
      while (rx_q.size() < p + 100 && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      rst = 1'b1; out_rdy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; out_rdy = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid reset");
      chk("bytes before reset", rx_q.size(), p + 100);
      while (exp_q.size() > rx_q.size()) void'(exp_q.pop_back());
      wcnt = 0;
      check_stream("pre-reset");
      @(negedge clk);
      chk("mid reset idle data_ov", data_ov, 0);
      p = rx_q.size();
      write_words(WPB, 16'h5A00, 16'h0123);
      drain(2000);
      check_stream("post-reset");
      check_gaps(p, "post-reset");
      chk("final stall hold errors", stall_err, 0);
      chk("final ovf", ovf, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
